// File: rtl/reg_alu_core.sv
// reg_alu_core: register-file ALU core with busy/done handshake.
//
// Holds NREGS registers of WIDTH bits and runs one three-address operation
// at a time (dst <- A op B). Carry, zero and negative flags are kept in a
// flag register. A command strobe is only honoured while the core is idle.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : op 12 is a WIDTH-cycle unsigned shift-add multiply
//   undefined : op 12 is a NOP; no multiplier hardware and no MUL state
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   data_in, load, ce      load data / load-vs-execute select / command strobe
//   dst_sel, a_sel, b_sel  destination and operand register selects
//   op, cin                operation code and carry in (latched with command)
//   rd_sel, data_out       combinational read port
//   cout, zero, neg        flag register
//   busy, done             execute in progress / one-cycle completion pulse
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting load/execute commands
// EXEC  | single-cycle ALU op; writeback and flags at end of cycle
// MUL   | shift-add multiply, one step per cycle (ALU_MUL_EN only)

module reg_alu_core #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     load,
    input  logic                     ce,
    input  logic [$clog2(NREGS)-1:0] dst_sel,
    input  logic [$clog2(NREGS)-1:0] a_sel,
    input  logic [$clog2(NREGS)-1:0] b_sel,
    input  logic [3:0]               op,
    input  logic                     cin,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    output logic [WIDTH-1:0]         data_out,
    output logic                     cout,
    output logic                     zero,
    output logic                     neg,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(NREGS);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_CMP  = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC
`ifdef ALU_MUL_EN
        ,S_MUL
`endif
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic [AW-1:0]    dst_q;
    logic             cin_q;
    logic             c_q, z_q, n_q;
    logic             done_q;

    logic             load_cmd, exec_cmd;

    // ALU result for the latched command
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_wr;
    logic             alu_fl;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // writeback / flag controls from the output process
    logic             wb_en;
    logic [WIDTH-1:0] wb_data;
    logic             flag_en;
    logic             flag_c, flag_z, flag_n;
    logic             done_d;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mul_hi_q, mul_lo_q;
    logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
    logic [WIDTH:0]   mul_sum;
    logic [CW-1:0]    mul_cnt_q;
`endif

    // Commands are only seen while idle; anything during busy is dropped.
    assign load_cmd = (state_q == S_IDLE) && ce && load;
    assign exec_cmd = (state_q == S_IDLE) && ce && !load;

    assign data_out = regs[rd_sel];
    assign cout     = c_q;
    assign zero     = z_q;
    assign neg      = n_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (exec_cmd) begin
                    state_d = S_EXEC;
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) state_d = S_MUL;
`endif
                end
            end
            S_EXEC: state_d = S_IDLE;
`ifdef ALU_MUL_EN
            S_MUL:  if (mul_cnt_q == '0) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (writeback, flag update, done)
    // ---------------------------------------------------------------
    always_comb begin
        wb_en   = 1'b0;
        wb_data = alu_res;
        flag_en = 1'b0;
        flag_c  = alu_c;
        flag_z  = (alu_res == '0);
        flag_n  = alu_res[WIDTH-1];
        done_d  = 1'b0;
        case (state_q)
            S_EXEC: begin
                wb_en   = alu_wr;
                flag_en = alu_fl;
                done_d  = 1'b1;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (mul_cnt_q == '0) begin
                    wb_en   = 1'b1;
                    wb_data = mul_lo_d;
                    flag_en = 1'b1;
                    flag_c  = |mul_hi_d;
                    flag_z  = (mul_lo_d == '0);
                    flag_n  = mul_lo_d[WIDTH-1];
                    done_d  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // ALU on the snapshotted operands
    // ---------------------------------------------------------------
    // The (WIDTH+1)-bit difference has its top bit set exactly when the
    // unsigned minuend is smaller than the subtrahend (+ borrow in).
    assign sum_ext  = {1'b0, a_q} + {1'b0, b_q}
                    + {{WIDTH{1'b0}}, (op_q == OP_ADC) & cin_q};
    assign diff_ext = {1'b0, a_q} - {1'b0, b_q}
                    - {{WIDTH{1'b0}}, (op_q == OP_SBC) & cin_q};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
        case (op_q)
            OP_ADD, OP_ADC: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            OP_SUB, OP_SBC: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
            end
            OP_CMP: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_wr  = 1'b0;
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_ROL: begin
                alu_res = {a_q[WIDTH-2:0], cin_q};
                alu_c   = a_q[WIDTH-1];
            end
            OP_ROR: begin
                alu_res = {cin_q, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_PASS: alu_res = b_q;
            // MUL only reaches EXEC when the multiplier is not built in
            OP_MUL, OP_NOP: begin
                alu_wr = 1'b0;
                alu_fl = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    // ---------------------------------------------------------------
    // Shift-add multiplier: {hi, lo} starts as {0, B}; each step adds A
    // into hi when lo[0] is set and shifts the pair right by one.
    // ---------------------------------------------------------------
    assign mul_sum  = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, a_q} : '0);
    assign mul_hi_d = mul_sum[WIDTH:1];
    assign mul_lo_d = {mul_sum[0], mul_lo_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_hi_q  <= '0;
            mul_lo_q  <= '0;
            mul_cnt_q <= '0;
        end else if (exec_cmd) begin
            mul_hi_q  <= '0;
            mul_lo_q  <= regs[b_sel];
            mul_cnt_q <= CW'(WIDTH - 1);
        end else if (state_q == S_MUL) begin
            mul_hi_q  <= mul_hi_d;
            mul_lo_q  <= mul_lo_d;
            mul_cnt_q <= mul_cnt_q - 1'b1;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Register file, operand snapshot, flags, done
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NOP;
            dst_q  <= '0;
            cin_q  <= 1'b0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // load and writeback are exclusive: one needs IDLE, the other busy
            for (int i = 0; i < NREGS; i++) begin
                if (load_cmd && dst_sel == AW'(i)) regs[i] <= data_in;
                if (wb_en && dst_q == AW'(i))      regs[i] <= wb_data;
            end
            if (exec_cmd) begin
                a_q   <= regs[a_sel];
                b_q   <= regs[b_sel];
                op_q  <= op;
                dst_q <= dst_sel;
                cin_q <= cin;
            end
            if (flag_en) begin
                c_q <= flag_c;
                z_q <= flag_z;
                n_q <= flag_n;
            end
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_alu_core.sv
module tb_reg_alu_core;

    localparam int W = 8;
    localparam int N = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load, ce;
    logic [2:0]   dst_sel, a_sel, b_sel, rd_sel;
    logic [3:0]   op;
    logic         cin;
    logic [W-1:0] data_out;
    logic         cout, zero, neg, busy, done;

    reg_alu_core #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ce(ce),
        .dst_sel(dst_sel), .a_sel(a_sel), .b_sel(b_sel), .op(op), .cin(cin),
        .rd_sel(rd_sel), .data_out(data_out), .cout(cout), .zero(zero),
        .neg(neg), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_regs [N];
    int m_c, m_z, m_n;

    typedef struct {
        bit is_load;
        int op, dst, a, b, cin, data;
        int exp_val, exp_c, exp_z, exp_n;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 0;
        m_c = 0; m_z = 0; m_n = 0;
    endtask

    // Plain-arithmetic reference of one execute command.
    task automatic model_exec(input int t_op, input int t_dst, input int t_a,
                              input int t_b, input int t_cin);
        int av, bv, r, c;
        bit wr, fl;
        av = m_regs[t_a]; bv = m_regs[t_b];
        r = 0; c = 0; wr = 1; fl = 1;
        case (t_op)
            0:  begin r = av + bv;          c = (r > 255); end
            1:  begin r = av + bv + t_cin;  c = (r > 255); end
            2:  begin r = av - bv;          c = (av < bv); end
            3:  begin r = av - bv - t_cin;  c = (av < bv + t_cin); end
            4:  r = av & bv;
            5:  r = av | bv;
            6:  r = av ^ bv;
            7:  r = 255 - av;
            8:  begin r = av * 2;               c = (av >= 128); end
            9:  begin r = av / 2;               c = av % 2; end
            10: begin r = av * 2 + t_cin;       c = (av >= 128); end
            11: begin r = av / 2 + t_cin * 128; c = av % 2; end
            12: begin
                if (MUL_EN) begin r = av * bv; c = (r > 255); end
                else begin wr = 0; fl = 0; end
            end
            13: r = bv;
            14: begin r = av - bv; c = (av < bv); wr = 0; end
            default: begin wr = 0; fl = 0; end
        endcase
        r = r & 255;
        if (wr) m_regs[t_dst] = r;
        if (fl) begin
            m_c = c;
            m_z = (r == 0);
            m_n = (r >= 128);
        end
    endtask

    task automatic sweep_regs(input string name);
        for (int i = 0; i < N; i++) begin
            rd_sel = 3'(i);
            #1;
            chk(name, int'(data_out), m_regs[i]);
        end
    endtask

    task automatic check_flags(input string name);
        chk({name, "_cout"}, int'(cout), m_c);
        chk({name, "_zero"}, int'(zero), m_z);
        chk({name, "_neg"},  int'(neg),  m_n);
    endtask

    // Returns at posedge+1 of the cycle after the load edge.
    task automatic do_load(input int t_dst, input int t_data);
        @(negedge clk);
        ce = 1; load = 1; dst_sel = 3'(t_dst); data_in = 8'(t_data);
        @(posedge clk); #1;
        ce = 0; load = 0;
        m_regs[t_dst] = t_data & 255;
        chk("load_busy", int'(busy), 0);
        chk("load_done", int'(done), 0);
        rd_sel = 3'(t_dst); #1;
        chk("load_data", int'(data_out), m_regs[t_dst]);
    endtask

    // Issues an execute, checks busy for the full latency and done in the
    // following cycle, then dst and flags. Returns inside the done cycle so
    // the next command can be issued back-to-back. With poke set, a load to
    // r7 is attempted while busy and must be dropped.
    task automatic do_exec(input int t_op, input int t_dst, input int t_a,
                           input int t_b, input int t_cin, input bit poke);
        int lat, poke_k;
        lat    = (t_op == 12 && MUL_EN) ? W : 1;
        poke_k = (lat > 1) ? 3 : 0;
        @(negedge clk);
        ce = 1; load = 0; op = 4'(t_op); dst_sel = 3'(t_dst);
        a_sel = 3'(t_a); b_sel = 3'(t_b); cin = t_cin[0];
        @(posedge clk); #1;
        ce = 0;
        model_exec(t_op, t_dst, t_a, t_b, t_cin);
        for (int k = 0; k < lat; k++) begin
            chk("exec_busy", int'(busy), 1);
            chk("exec_done_early", int'(done), 0);
            if (poke && k == poke_k) begin
                @(negedge clk);
                ce = 1; load = 1; dst_sel = 3'd7; data_in = 8'hA5;
                @(posedge clk); #1;
                ce = 0; load = 0;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("exec_done", int'(done), 1);
        chk("exec_busy_end", int'(busy), 0);
        rd_sel = 3'(t_dst); #1;
        chk("exec_dst", int'(data_out), m_regs[t_dst]);
        check_flags("exec");
        if (poke) begin
            rd_sel = 3'd7; #1;
            chk("busy_ce_dropped", int'(data_out), m_regs[7]);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_pulse_width", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic add_load(input int d, input int v);
        vec_t e;
        e = '{1'b1, 0, d, 0, 0, 0, v, v, 0, 0, 0};
        tbl.push_back(e);
    endtask

    task automatic add_op(input int o, input int d, input int a, input int b,
                          input int ci, input int ev, input int ec,
                          input int ez, input int en);
        vec_t e;
        e = '{1'b0, o, d, a, b, ci, 0, ev, ec, ez, en};
        tbl.push_back(e);
    endtask

    initial begin
        rst = 1; ce = 0; load = 0; data_in = '0; op = '0; cin = 0;
        dst_sel = '0; a_sel = '0; b_sel = '0; rd_sel = '0;
        model_reset();

        add_load(1, 8'hF0); add_load(2, 8'h20);
        add_op(0, 3, 1, 2, 0, 8'h10, 1, 0, 0);          // ADD
        add_load(1, 8'h05); add_load(2, 8'h05);
        add_op(2, 4, 1, 2, 0, 8'h00, 0, 1, 0);          // SUB
        add_op(14, 0, 0, 1, 0, 8'h00, 1, 0, 1);         // CMP r0 vs r1
        add_load(1, 8'h81);
        add_op(10, 1, 1, 0, 1, 8'h03, 1, 0, 0);         // ROL cin=1
        add_op(11, 1, 1, 0, 0, 8'h01, 1, 0, 0);         // ROR cin=0
        add_load(1, 8'h12); add_load(2, 8'h10);
        add_op(12, 5, 1, 2, 0, MUL_EN ? 8'h20 : 0, 1, 0, 0);  // MUL
        add_op(1, 6, 1, 2, 1, 8'h23, 0, 0, 0);          // ADC
        add_op(3, 6, 2, 1, 1, 8'hFD, 1, 0, 1);          // SBC
        add_op(4, 7, 1, 6, 0, 8'h10, 0, 0, 0);          // AND
        add_op(6, 0, 1, 1, 0, 8'h00, 0, 1, 0);          // XOR
        add_op(7, 0, 0, 0, 0, 8'hFF, 0, 0, 1);          // NOT
        add_op(9, 6, 6, 0, 0, 8'h7E, 1, 0, 0);          // SHR
        add_op(8, 7, 6, 0, 0, 8'hFC, 0, 0, 1);          // SHL
        add_op(13, 3, 0, 2, 0, 8'h10, 0, 0, 0);         // PASS
        add_op(15, 3, 1, 2, 1, 8'h10, 0, 0, 0);         // NOP
        add_op(5, 4, 1, 2, 0, 8'h12, 0, 0, 0);          // OR

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        check_flags("rst");
        sweep_regs("rst_reg");
        rst = 0;

        // directed table
        foreach (tbl[i]) begin
            if (tbl[i].is_load) begin
                do_load(tbl[i].dst, tbl[i].data);
            end else begin
                do_exec(tbl[i].op, tbl[i].dst, tbl[i].a, tbl[i].b,
                        tbl[i].cin, tbl[i].op == 12);
                rd_sel = 3'(tbl[i].dst); #1;
                chk("tbl_val", int'(data_out), tbl[i].exp_val);
                chk("tbl_cout", int'(cout), tbl[i].exp_c);
                chk("tbl_zero", int'(zero), tbl[i].exp_z);
                chk("tbl_neg",  int'(neg),  tbl[i].exp_n);
            end
            idle_cycle();
        end
        sweep_regs("tbl_sweep");

        // reset in the EXEC cycle aborts the op
        @(negedge clk);
        ce = 1; load = 0; op = 4'd0; dst_sel = 3'd3; a_sel = 3'd1; b_sel = 3'd2;
        cin = 0;
        @(posedge clk); #1;
        ce = 0;
        chk("abort_busy_before", int'(busy), 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        check_flags("abort");
        sweep_regs("abort_reg");
        idle_cycle();
        do_load(4, 8'h5A);

        // ce together with rst is ignored
        @(negedge clk);
        rst = 1; ce = 1; load = 1; dst_sel = 3'd2; data_in = 8'h77;
        @(posedge clk); #1;
        rst = 0; ce = 0; load = 0;
        model_reset();
        sweep_regs("ce_with_rst");
        do_load(2, 8'h3C);

        // randomized back-to-back traffic against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_load(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
            else
                do_exec(int'($urandom_range(0, 15)), int'($urandom_range(0, N - 1)),
                        int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                        int'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end
        idle_cycle();
        sweep_regs("rand_sweep");
        check_flags("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_alu_core.md
# reg_alu_core

Parametrised register-file ALU core: the next-generation execution block of the CPU datapath, generalised in data width and register count. Holds NREGS general registers, executes one three-address operation at a time (dst ← A op B), and keeps carry/zero/negative flags. Adds a busy/done handshake and an optional iterative multiplier. Sits between the host-side load/command interface and the datapath result bus.

## Interface
- WIDTH, 8, data and register width in bits (≥4)
- NREGS, 8, number of registers; power of two, ≥2; AW = log2(NREGS) is derived internally
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  WIDTH  load data
- load  in  1  with ce: register-write command; without load: execute command
- ce  in  1  command strobe; sampled only while busy=0
- dst_sel  in  AW  destination register (load and execute)
- a_sel, b_sel  in  AW  operand register selects
- op  in  4  operation code
- cin  in  1  carry in, latched with the command
- rd_sel  in  AW  read-port select
- data_out  out  WIDTH  combinational reg[rd_sel]
- cout, zero, neg  out  1 each  flag register
- busy  out  1  execute in progress
- done  out  1  one-cycle pulse after writeback

## Operation
- States: IDLE, EXEC, MUL. Reset → IDLE; all registers, flags, busy and done are 0.
- IDLE, ce=1, load=1: reg[dst_sel] ← data_in at the edge. Flags unchanged, busy stays 0, no done pulse.
- IDLE, ce=1, load=0: snapshot reg[a_sel] into A and reg[b_sel] into B, and latch op, dst_sel and cin. Go to EXEC (or MUL for op 12 when the multiplier is compiled in).
- ce while busy=1 is ignored; the command is dropped with no side effect.
- Operations (R = result):
  - 0 ADD: A+B
  - 1 ADC: A+B+cin
  - 2 SUB: A−B
  - 3 SBC: A−B−cin
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOT: ~A
  - 8 SHL: A<<1
  - 9 SHR: A>>1, logical
  - 10 ROL: through carry
  - 11 ROR: through carry
  - 12 MUL
  - 13 PASS: B
  - 14 CMP: A−B, flags only, no register write
  - 15 NOP
- cout rules:
  - ADD/ADC: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB/SBC/CMP: borrow, i.e. 1 when the unsigned minuend is less than the subtrahend.
  - SHL/ROL: old A MSB. SHR/ROR: old A LSB. ROL/ROR shift the latched cin into the vacated bit.
  - Logic ops and PASS: cout cleared.
  - MUL: OR of the upper WIDTH product bits.
- zero = (R==0), neg = R[WIDTH-1]. All three flags update on every op except NOP, which leaves them unchanged.
- Register 0 has no special role. dst may equal a_sel or b_sel because operands are snapshotted.

## Timing
- Command accepted in cycle T (IDLE, ce=1).
  - T+1: EXEC, busy=1; writeback and flag update at the end of T+1.
  - T+2: IDLE, busy=0, done=1 for exactly one cycle.
- A new ce is accepted in the done cycle. Throughput is one op per 2 cycles.
- Load: write visible on data_out in T+1.
- MUL: states MUL for cycles T+1…T+WIDTH, one shift-add step per cycle.
  - Writeback at the end of T+WIDTH; done in T+WIDTH+1.
- NOP and CMP use the 2-cycle timing and still pulse done.
- Reset asserted mid-operation aborts the operation: no writeback, no done. Everything is back at reset values the cycle after reset.
- ce=1 in the same cycle as rst=1 is ignored.

## Configuration
- ALU_MUL_EN defined: op 12 is a WIDTH-cycle unsigned shift-add multiply.
  - dst ← low WIDTH bits of A×B.
  - cout = |high bits; zero/neg taken from the low half.
- ALU_MUL_EN undefined: op 12 behaves exactly as NOP (2-cycle, done pulses, no write, flags unchanged). No multiplier logic is present and the MUL state does not exist.

## Test plan
- WIDTH=8. Load r1=0xF0, r2=0x20. ADD dst=r3 → r3=0x10, cout=1, zero=0, neg=0. done in T+2, busy high only in T+1.
- Load r1=0x05, r2=0x05. SUB dst=r4 → r4=0x00, zero=1, cout=0. Then CMP r0(0) vs r1 → cout=1, neg=1, r0 unchanged.
- r1=0x81, cin=1, ROL dst=r1 → r1=0x03, cout=1. Then ROR with cin=0 → r1=0x01, cout=1.
- ALU_MUL_EN set: r1=0x12, r2=0x10, MUL dst=r5 → r5=0x20, cout=1. done at T+9; a ce issued at T+4 is ignored.
- ALU_MUL_EN unset: MUL → registers and flags unchanged, done at T+2.
- Start ADD, assert rst in T+1 → no writeback, no done. All regs, flags and busy are 0 afterwards, and a load in the next cycle succeeds.
